// File: rtl/vdp_vram_arb_pkg.sv
// Shared types and constants for the super-res VRAM arbiter.
//   owner_t     : which requester owns the current 4-cycle window
//   arb_state_t : window state machine, locked to cx[1:0]
//   PH_*        : window phase values (cx[1:0]) at which each state is entered
package vdp_vram_arb_pkg;

  typedef enum logic [2:0] {NONE, REFRESH, DISP, CPU, CMD} owner_t;

  typedef enum logic [1:0] {ARB, ISSUE, WAIT, RET} arb_state_t;

  localparam logic [1:0] PH_ARB   = 2'd0;
  localparam logic [1:0] PH_ISSUE = 2'd1;
  localparam logic [1:0] PH_WAIT  = 2'd2;
  localparam logic [1:0] PH_RET   = 2'd3;

endpackage

// File: rtl/vdp_vram_byte_lane.sv
// Byte-lane helper for 8-bit requesters on the 32-bit VRAM port.
//   lane  : byte address bits [1:0]
//   wbyte : byte to write
//   rword : 32-bit word read from VRAM
//   wmask : one-hot byte-lane write mask
//   wword : write byte replicated across all four lanes
//   rbyte : byte selected from rword by lane
module vdp_vram_byte_lane (
  input  logic [1:0]  lane,
  input  logic [7:0]  wbyte,
  input  logic [31:0] rword,
  output logic [3:0]  wmask,
  output logic [31:0] wword,
  output logic [7:0]  rbyte
);

  assign wmask = 4'b0001 << lane;
  assign wword = {4{wbyte}};

  always_comb begin
    rbyte = rword[7:0];
    unique case (lane)
      2'd0: rbyte = rword[7:0];
      2'd1: rbyte = rword[15:8];
      2'd2: rbyte = rword[23:16];
      2'd3: rbyte = rword[31:24];
      default: rbyte = rword[7:0];
    endcase
  end

endmodule

// File: rtl/vdp_super_vram_arbiter.sv
// Shared VRAM port scheduler for super-res display fetch, CPU byte port,
// command-engine byte port and refresh. Time is split into 4-cycle windows
// aligned to cx[1:0]; each window carries at most one 32-bit access.
//   clk, reset_n             : pixel clock, async active-low reset
//   vdp_super, cx            : super-res enable, horizontal counter
//   refresh_req              : refresh wanted this window
//   disp_*                   : display fetch request/address and returned word
//   cpu_* / cmd_*            : byte requesters (req held until ack)
//   mem_*                    : VRAM controller port
module vdp_super_vram_arbiter
  import vdp_vram_arb_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned WORD_ADDR_W  = 17
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   vdp_super,
  input  logic [10:0]            cx,
  input  logic                   refresh_req,
  input  logic                   disp_req,
  input  logic [WORD_ADDR_W-1:0] disp_addr,
  output logic [31:0]            disp_rdata,
  output logic                   disp_valid,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [WORD_ADDR_W+1:0] cpu_addr,
  input  logic [7:0]             cpu_wdata,
  output logic                   cpu_ack,
  output logic [7:0]             cpu_rdata,
  input  logic                   cmd_req,
  input  logic                   cmd_we,
  input  logic [WORD_ADDR_W+1:0] cmd_addr,
  input  logic [7:0]             cmd_wdata,
  output logic                   cmd_ack,
  output logic [7:0]             cmd_rdata,
  output logic                   mem_req,
  output logic                   mem_refresh,
  output logic                   mem_we,
  output logic [WORD_ADDR_W-1:0] mem_addr,
  output logic [3:0]             mem_wmask,
  output logic [31:0]            mem_wdata,
  input  logic [31:0]            mem_rdata
);

  logic [1:0] phase;
  logic       unused_cx;

  assign phase     = cx[1:0];
  assign unused_cx = ^cx[10:2];

  arb_state_t state_q;
  owner_t     owner_q;
  owner_t     rr_last_q;
  logic [1:0] lane_q;
  logic       we_q;
  logic [31:0] word_q;

  owner_t                 grant;
  logic [WORD_ADDR_W+1:0] sel_addr;
  logic                   sel_we;
  logic [7:0]             sel_wdata;
  logic [1:0]             lane_sel;
  logic [31:0]            ret_word;
  logic [3:0]             lane_wmask;
  logic [31:0]            lane_wword;
  logic [7:0]             lane_rbyte;

  // Fixed priority refresh > display > round-robin CPU/CMD.
  always_comb begin
    grant = NONE;
    if (refresh_req) begin
      grant = REFRESH;
    end else if (disp_req && vdp_super) begin
      grant = DISP;
    end else if (cpu_req && cmd_req) begin
      grant = (rr_last_q == CPU) ? CMD : CPU;
    end else if (cpu_req) begin
      grant = CPU;
    end else if (cmd_req) begin
      grant = CMD;
    end
  end

  always_comb begin
    sel_addr  = cpu_addr;
    sel_we    = cpu_we;
    sel_wdata = cpu_wdata;
    if (grant == CMD) begin
      sel_addr  = cmd_addr;
      sel_we    = cmd_we;
      sel_wdata = cmd_wdata;
    end
  end

  // The single lane helper sees the live requester address while arbitrating,
  // and the latched lane afterwards for read-byte selection.
  assign lane_sel = (state_q == ARB) ? sel_addr[1:0] : lane_q;

  // With latency 2 the word arrives exactly on the delivery edge; with
  // latency 1 it was parked in word_q one cycle earlier.
  assign ret_word = (READ_LATENCY >= 2) ? mem_rdata : word_q;

  vdp_vram_byte_lane u_byte_lane (
    .lane  (lane_sel),
    .wbyte (sel_wdata),
    .rword (ret_word),
    .wmask (lane_wmask),
    .wword (lane_wword),
    .rbyte (lane_rbyte)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ARB;
      owner_q     <= NONE;
      rr_last_q   <= CMD;
      lane_q      <= 2'd0;
      we_q        <= 1'b0;
      word_q      <= 32'd0;
      mem_req     <= 1'b0;
      mem_refresh <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wmask   <= 4'd0;
      mem_wdata   <= 32'd0;
      disp_rdata  <= 32'd0;
      disp_valid  <= 1'b0;
      cpu_ack     <= 1'b0;
      cpu_rdata   <= 8'd0;
      cmd_ack     <= 1'b0;
      cmd_rdata   <= 8'd0;
    end else begin
      // Strobes and acks are single-cycle pulses.
      mem_req     <= 1'b0;
      mem_refresh <= 1'b0;
      mem_we      <= 1'b0;
      disp_valid  <= 1'b0;
      cpu_ack     <= 1'b0;
      cmd_ack     <= 1'b0;

      unique case (state_q)
        ARB: begin
          // Idle here until a window boundary (e.g. after a mid-window reset).
          if (phase == PH_ARB) begin
            state_q <= ISSUE;
            owner_q <= grant;
            lane_q  <= sel_addr[1:0];
            we_q    <= sel_we;
            case (grant)
              REFRESH: mem_refresh <= 1'b1;
              DISP: begin
                mem_req   <= 1'b1;
                mem_addr  <= disp_addr;
                mem_wmask <= 4'd0;
              end
              CPU, CMD: begin
                mem_req   <= 1'b1;
                mem_we    <= sel_we;
                mem_addr  <= sel_addr[WORD_ADDR_W+1:2];
                mem_wmask <= sel_we ? lane_wmask : 4'd0;
                mem_wdata <= lane_wword;
                rr_last_q <= grant;
              end
              default: ;
            endcase
          end
        end

        ISSUE: begin
          if (READ_LATENCY < 2) word_q <= mem_rdata;
          state_q <= WAIT;
          // Lost window lock: drop the access rather than deliver stale data.
          if (phase != PH_ISSUE) begin
            state_q <= ARB;
            owner_q <= NONE;
          end
        end

        WAIT: begin
          state_q <= RET;
          if (phase != PH_WAIT) begin
            state_q <= ARB;
            owner_q <= NONE;
          end else begin
            case (owner_q)
              DISP: begin
                disp_valid <= 1'b1;
                disp_rdata <= ret_word;
              end
              CPU: begin
                cpu_ack <= 1'b1;
                if (!we_q) cpu_rdata <= lane_rbyte;
              end
              CMD: begin
                cmd_ack <= 1'b1;
                if (!we_q) cmd_rdata <= lane_rbyte;
              end
              default: ;
            endcase
          end
        end

        RET: begin
          state_q <= ARB;
          owner_q <= NONE;
        end

        default: begin
          state_q <= ARB;
          owner_q <= NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vdp_super_vram_arbiter.sv
// Directed self-checking bench for vdp_super_vram_arbiter.
module tb_vdp_super_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        vdp_super = 1'b0;
  logic [10:0] cx = 11'd0;
  logic        refresh_req = 1'b0;
  logic        disp_req = 1'b0;
  logic [16:0] disp_addr = 17'd0;
  logic [31:0] disp_rdata;
  logic        disp_valid;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [18:0] cpu_addr = 19'd0;
  logic [7:0]  cpu_wdata = 8'd0;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        cmd_req = 1'b0, cmd_we = 1'b0;
  logic [18:0] cmd_addr = 19'd0;
  logic [7:0]  cmd_wdata = 8'd0;
  logic        cmd_ack;
  logic [7:0]  cmd_rdata;
  logic        mem_req, mem_refresh, mem_we;
  logic [16:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;

  int total = 0;
  int bad = 0;

  vdp_super_vram_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .vdp_super   (vdp_super),
    .cx          (cx),
    .refresh_req (refresh_req),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_rdata  (disp_rdata),
    .disp_valid  (disp_valid),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ack     (cpu_ack),
    .cpu_rdata   (cpu_rdata),
    .cmd_req     (cmd_req),
    .cmd_we      (cmd_we),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_ack     (cmd_ack),
    .cmd_rdata   (cmd_rdata),
    .mem_req     (mem_req),
    .mem_refresh (mem_refresh),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wmask   (mem_wmask),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  // Free-running pixel clock; cx advances just after each rising edge.
  initial begin
    forever begin
      #5 clk = 1'b1;
      #1 cx = cx + 11'd1;
      #4 clk = 1'b0;
    end
  end

  // Advance to the next falling edge whose cycle has window phase p.
  task automatic goto_phase(input logic [1:0] p);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cx[1:0] != p && n < 8);
    if (cx[1:0] != p) begin
      bad++;
      $display("FAIL goto_phase got=%0d want=%0d", cx[1:0], p);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset_n = 1'b0;
    refresh_req = 0; disp_req = 0; cpu_req = 0; cmd_req = 0; cpu_we = 0; cmd_we = 0;
    repeat (3) @(negedge clk);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%0h want=0", mem_req); end
    total++; if (mem_refresh !== 1'b0) begin bad++; $display("FAIL reset_mem_refresh got=%0h want=0", mem_refresh); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%0h want=0", mem_we); end
    total++; if (mem_addr !== 17'd0) begin bad++; $display("FAIL reset_mem_addr got=%0h want=0", mem_addr); end
    total++; if (mem_wmask !== 4'd0) begin bad++; $display("FAIL reset_mem_wmask got=%0h want=0", mem_wmask); end
    total++; if (mem_wdata !== 32'd0) begin bad++; $display("FAIL reset_mem_wdata got=%0h want=0", mem_wdata); end
    total++; if (disp_valid !== 1'b0) begin bad++; $display("FAIL reset_disp_valid got=%0h want=0", disp_valid); end
    total++; if (disp_rdata !== 32'd0) begin bad++; $display("FAIL reset_disp_rdata got=%0h want=0", disp_rdata); end
    total++; if ({cpu_ack, cmd_ack} !== 2'b00) begin bad++; $display("FAIL reset_acks got=%0b want=00", {cpu_ack, cmd_ack}); end
    total++; if ({cpu_rdata, cmd_rdata} !== 16'd0) begin bad++; $display("FAIL reset_rdata got=%0h want=0", {cpu_rdata, cmd_rdata}); end
    reset_n = 1'b1;
  endtask

  task automatic test_display;
    logic [31:0] words [2];
    words[0] = 32'hDEADBEEF;
    words[1] = 32'hCAFEF00D;
    goto_phase(2'd0);
    vdp_super = 1; disp_req = 1; disp_addr = 17'h00010;
    for (int w = 0; w < 2; w++) begin
      mem_rdata = words[w];
      goto_phase(2'd1);
      total++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL disp_issue w=%0d got req=%0h we=%0h want req=1 we=0", w, mem_req, mem_we); end
      total++; if (mem_addr !== 17'h00010) begin bad++; $display("FAIL disp_addr w=%0d got=%0h want=10", w, mem_addr); end
      goto_phase(2'd3);
      total++; if (disp_valid !== 1'b1) begin bad++; $display("FAIL disp_valid w=%0d got=%0h want=1", w, disp_valid); end
      total++; if (disp_rdata !== words[w]) begin bad++; $display("FAIL disp_rdata w=%0d got=%0h want=%0h", w, disp_rdata, words[w]); end
      if (w == 1) disp_req = 0;
      goto_phase(2'd0);
      total++; if (disp_valid !== 1'b0) begin bad++; $display("FAIL disp_valid_pulse w=%0d got=%0h want=0", w, disp_valid); end
    end
    goto_phase(2'd1);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL disp_dropped got=%0h want=0", mem_req); end
    // Display requests are ignored outside super-res mode.
    disp_req = 1; vdp_super = 0;
    goto_phase(2'd1);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL disp_nosuper_req got=%0h want=0", mem_req); end
    goto_phase(2'd3);
    total++; if (disp_valid !== 1'b0 || disp_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL disp_nosuper got valid=%0h data=%0h want 0 cafef00d", disp_valid, disp_rdata); end
    disp_req = 0; vdp_super = 1;
  endtask

  task automatic test_cpu_write;
    goto_phase(2'd0);
    cpu_req = 1; cpu_we = 1; cpu_addr = 19'h00006; cpu_wdata = 8'h5A;
    goto_phase(2'd1);
    total++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin bad++; $display("FAIL wr_issue got req=%0h we=%0h want 1 1", mem_req, mem_we); end
    total++; if (mem_addr !== 17'h00001) begin bad++; $display("FAIL wr_addr got=%0h want=1", mem_addr); end
    total++; if (mem_wmask !== 4'b0100) begin bad++; $display("FAIL wr_wmask got=%0b want=0100", mem_wmask); end
    total++; if (mem_wdata !== 32'h5A5A5A5A) begin bad++; $display("FAIL wr_wdata got=%0h want=5a5a5a5a", mem_wdata); end
    goto_phase(2'd2);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL wr_req_pulse got=%0h want=0", mem_req); end
    goto_phase(2'd3);
    total++; if (cpu_ack !== 1'b1 || cmd_ack !== 1'b0) begin bad++; $display("FAIL wr_ack got cpu=%0h cmd=%0h want 1 0", cpu_ack, cmd_ack); end
    cpu_req = 0; cpu_we = 0;
    goto_phase(2'd0);
    total++; if (cpu_ack !== 1'b0) begin bad++; $display("FAIL wr_ack_pulse got=%0h want=0", cpu_ack); end
  endtask

  task automatic test_reads;
    goto_phase(2'd0);
    cpu_req = 1; cpu_we = 0; cpu_addr = 19'h00007; mem_rdata = 32'h11223344;
    goto_phase(2'd1);
    total++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_wmask !== 4'd0) begin bad++; $display("FAIL rd_issue got req=%0h we=%0h mask=%0b want 1 0 0000", mem_req, mem_we, mem_wmask); end
    goto_phase(2'd3);
    total++; if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h11) begin bad++; $display("FAIL cpu_rd got ack=%0h data=%0h want 1 11", cpu_ack, cpu_rdata); end
    cpu_req = 0;
    goto_phase(2'd0);
    cmd_req = 1; cmd_we = 0; cmd_addr = 19'h40001;
    goto_phase(2'd1);
    total++; if (mem_addr !== 17'h10000) begin bad++; $display("FAIL cmd_rd_addr got=%0h want=10000", mem_addr); end
    goto_phase(2'd3);
    total++; if (cmd_ack !== 1'b1 || cpu_ack !== 1'b0 || cmd_rdata !== 8'h33) begin bad++; $display("FAIL cmd_rd got ack=%0h cpu_ack=%0h data=%0h want 1 0 33", cmd_ack, cpu_ack, cmd_rdata); end
    total++; if (cpu_rdata !== 8'h11) begin bad++; $display("FAIL cpu_rdata_hold got=%0h want=11", cpu_rdata); end
    cmd_req = 0;
  endtask

  task automatic test_round_robin;
    test_reset;
    goto_phase(2'd0);
    cpu_req = 1; cpu_we = 0; cpu_addr = 19'h00000;
    cmd_req = 1; cmd_we = 0; cmd_addr = 19'h00002;
    mem_rdata = 32'h11223344;
    for (int w = 0; w < 4; w++) begin
      goto_phase(2'd3);
      total++;
      if (cpu_ack !== (w % 2 == 0) || cmd_ack !== (w % 2 == 1)) begin
        bad++;
        $display("FAIL rr_window w=%0d got cpu=%0h cmd=%0h want cpu=%0h cmd=%0h", w, cpu_ack, cmd_ack, (w % 2 == 0), (w % 2 == 1));
      end
      if (w == 3) begin cpu_req = 0; cmd_req = 0; end
    end
    total++; if (cpu_rdata !== 8'h44 || cmd_rdata !== 8'h22) begin bad++; $display("FAIL rr_rdata got cpu=%0h cmd=%0h want 44 22", cpu_rdata, cmd_rdata); end
  endtask

  task automatic test_priority;
    goto_phase(2'd0);
    refresh_req = 1; vdp_super = 1; disp_req = 1; disp_addr = 17'h00123;
    cpu_req = 1; cpu_we = 0; cpu_addr = 19'h00000; mem_rdata = 32'h55667788;
    goto_phase(2'd1);
    total++; if (mem_refresh !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL pri_refresh got ref=%0h req=%0h want 1 0", mem_refresh, mem_req); end
    goto_phase(2'd3);
    total++; if (disp_valid !== 1'b0 || cpu_ack !== 1'b0) begin bad++; $display("FAIL pri_refresh_noack got dv=%0h ack=%0h want 0 0", disp_valid, cpu_ack); end
    refresh_req = 0;
    goto_phase(2'd1);
    total++; if (mem_req !== 1'b1 || mem_refresh !== 1'b0 || mem_addr !== 17'h00123) begin bad++; $display("FAIL pri_disp got req=%0h ref=%0h addr=%0h want 1 0 123", mem_req, mem_refresh, mem_addr); end
    goto_phase(2'd3);
    total++; if (disp_valid !== 1'b1 || cpu_ack !== 1'b0 || disp_rdata !== 32'h55667788) begin bad++; $display("FAIL pri_disp_ret got dv=%0h ack=%0h data=%0h want 1 0 55667788", disp_valid, cpu_ack, disp_rdata); end
    disp_req = 0;
    goto_phase(2'd1);
    total++; if (mem_req !== 1'b1 || mem_addr !== 17'h00000) begin bad++; $display("FAIL pri_cpu got req=%0h addr=%0h want 1 0", mem_req, mem_addr); end
    goto_phase(2'd3);
    total++; if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h88) begin bad++; $display("FAIL pri_cpu_ret got ack=%0h data=%0h want 1 88", cpu_ack, cpu_rdata); end
    cpu_req = 0;
  endtask

  task automatic test_reset_mid;
    goto_phase(2'd0);
    cpu_req = 1; cpu_we = 0; cpu_addr = 19'h00005; mem_rdata = 32'hA1B2C3D4;
    goto_phase(2'd1);
    total++; if (mem_req !== 1'b1 || mem_addr !== 17'h00001) begin bad++; $display("FAIL mid_issue got req=%0h addr=%0h want 1 1", mem_req, mem_addr); end
    goto_phase(2'd2);
    reset_n = 1'b0;
    goto_phase(2'd3);
    total++; if (cpu_ack !== 1'b0 || cpu_rdata !== 8'h00) begin bad++; $display("FAIL mid_abandon got ack=%0h data=%0h want 0 0", cpu_ack, cpu_rdata); end
    reset_n = 1'b1;
    goto_phase(2'd1);
    total++; if (mem_req !== 1'b1 || mem_addr !== 17'h00001) begin bad++; $display("FAIL mid_reissue got req=%0h addr=%0h want 1 1", mem_req, mem_addr); end
    goto_phase(2'd3);
    total++; if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hC3) begin bad++; $display("FAIL mid_ack got ack=%0h data=%0h want 1 c3", cpu_ack, cpu_rdata); end
    cpu_req = 0;
    goto_phase(2'd0);
    total++; if (cpu_ack !== 1'b0) begin bad++; $display("FAIL mid_ack_pulse got=%0h want=0", cpu_ack); end
  endtask

  initial begin
    test_reset;
    test_display;
    test_cpu_write;
    test_reads;
    test_round_robin;
    test_priority;
    test_reset_mid;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
